// File: rtl/half_subtractor_bank.sv
// half_subtractor_bank: WIDTH independent 1-bit half subtractors with a
// combinational result path, a one-cycle registered result path, and a
// saturating count of borrowing lanes over accepted beats.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid              qualifies minuend/subtrahend for the registered path
//   minuend, subtrahend   per-lane operand bits
//   cnt_clr               synchronous clear of borrow_cnt (wins over accumulation)
//   diff, borrow_out      combinational per-lane difference and borrow
//   diff_q, borrow_q      registered diff/borrow_out, held when in_valid=0
//   out_valid             registered in_valid
//   borrow_cnt            saturating count of borrowing lanes
module half_subtractor_bank #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] diff,
  output logic [WIDTH-1:0] borrow_out,
  output logic [WIDTH-1:0] diff_q,
  output logic [WIDTH-1:0] borrow_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] borrow_cnt
);

  // Popcount width and an accumulator wide enough that the add never wraps.
  localparam int unsigned POP_W = $clog2(WIDTH + 1);
  localparam int unsigned SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

  logic [POP_W-1:0] borrow_pop;
  logic [SUM_W-1:0] cnt_sum;
  logic [CNT_W-1:0] cnt_nxt;

  // Per-lane half subtractor; lanes never interact.
  assign diff       = minuend ^ subtrahend;
  assign borrow_out = ~minuend & subtrahend;

  // Number of borrowing lanes this beat.
  always_comb begin
    borrow_pop = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      borrow_pop = borrow_pop + POP_W'(borrow_out[i]);
    end
  end

  // Saturating accumulate; clear has priority over an accepted beat.
  always_comb begin
    cnt_sum = SUM_W'(borrow_cnt) + SUM_W'(borrow_pop);
    cnt_nxt = borrow_cnt;
    if (cnt_clr) begin
      cnt_nxt = '0;
    end else if (in_valid) begin
      if (cnt_sum > SUM_W'({CNT_W{1'b1}})) begin
        cnt_nxt = '1;
      end else begin
        cnt_nxt = cnt_sum[CNT_W-1:0];
      end
    end
  end

  // Registered result path; operands captured only on accepted beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q     <= '0;
      borrow_q   <= '0;
      out_valid  <= 1'b0;
      borrow_cnt <= '0;
    end else begin
      out_valid  <= in_valid;
      borrow_cnt <= cnt_nxt;
      if (in_valid) begin
        diff_q   <= diff;
        borrow_q <= borrow_out;
      end
    end
  end

endmodule

// File: tb/tb_half_subtractor_bank.sv
module tb_half_subtractor_bank;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 4;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] borrow;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] minuend;
  logic [WIDTH-1:0] subtrahend;
  logic             cnt_clr;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] borrow_out;
  logic [WIDTH-1:0] diff_q;
  logic [WIDTH-1:0] borrow_q;
  logic             out_valid;
  logic [CNT_W-1:0] borrow_cnt;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  half_subtractor_bank #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .minuend    (minuend),
    .subtrahend (subtrahend),
    .cnt_clr    (cnt_clr),
    .diff       (diff),
    .borrow_out (borrow_out),
    .diff_q     (diff_q),
    .borrow_q   (borrow_q),
    .out_valid  (out_valid),
    .borrow_cnt (borrow_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every presented registered result is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("diff_q",     32'(diff_q),     32'(e.diff));
        check("borrow_q",   32'(borrow_q),   32'(e.borrow));
        check("borrow_cnt", 32'(borrow_cnt), 32'(e.cnt));
      end
    end
  end

  task automatic comb_check(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] s,
                            input logic [WIDTH-1:0] ed, input logic [WIDTH-1:0] eb);
    minuend    = m;
    subtrahend = s;
    #1;
    check("diff_comb",   32'(diff),       32'(ed));
    check("borrow_comb", 32'(borrow_out), 32'(eb));
  endtask

  // One cycle of stimulus with hand-computed expectations; valid beats are
  // queued for the monitor, non-valid cycles are checked here after the edge.
  task automatic beat(input logic v, input logic clr,
                      input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] s,
                      input logic [WIDTH-1:0] ed, input logic [WIDTH-1:0] eb,
                      input logic [CNT_W-1:0] ecnt,
                      input logic [WIDTH-1:0] hold_d, input logic [WIDTH-1:0] hold_b);
    @(negedge clk);
    #2;
    in_valid   = v;
    cnt_clr    = clr;
    minuend    = m;
    subtrahend = s;
    #1;
    check("diff_live",   32'(diff),       32'(ed));
    check("borrow_live", 32'(borrow_out), 32'(eb));
    if (v) sb.push_back('{diff: ed, borrow: eb, cnt: ecnt});
    @(posedge clk);
    #1;
    if (!v) begin
      check("out_valid_idle", 32'(out_valid),  32'd0);
      check("diff_q_hold",    32'(diff_q),     32'(hold_d));
      check("borrow_q_hold",  32'(borrow_q),   32'(hold_b));
      check("cnt_idle",       32'(borrow_cnt), 32'(ecnt));
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; cnt_clr = 1'b0;
    minuend = '0; subtrahend = '0;
    #1;
    check("rst_out_valid", 32'(out_valid),  32'd0);
    check("rst_diff_q",    32'(diff_q),     32'd0);
    check("rst_borrow_q",  32'(borrow_q),   32'd0);
    check("rst_cnt",       32'(borrow_cnt), 32'd0);

    // Truth table on every lane, no clock dependency, during reset.
    comb_check(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    comb_check(4'b0000, 4'b1111, 4'b1111, 4'b1111);
    comb_check(4'b1111, 4'b0000, 4'b1111, 4'b0000);
    comb_check(4'b1111, 4'b1111, 4'b0000, 4'b0000);
    comb_check(4'b1100, 4'b1010, 4'b0110, 4'b0010);

    @(negedge clk);
    rst_n = 1'b1;

    // First accepted beat after reset.
    beat(1'b1, 1'b0, 4'b1100, 4'b1010, 4'b0110, 4'b0010, 4'd1, 4'b0, 4'b0);
    // Idle with changing inputs: registered outputs and count hold.
    beat(1'b0, 1'b0, 4'b0001, 4'b1000, 4'b1001, 4'b1000, 4'd1, 4'b0110, 4'b0010);
    beat(1'b0, 1'b1, 4'b0011, 4'b0101, 4'b0110, 4'b0100, 4'd0, 4'b0110, 4'b0010);
    // Saturation: 4 borrows per beat into a 4-bit counter.
    beat(1'b1, 1'b0, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'd4,  4'b0, 4'b0);
    beat(1'b1, 1'b0, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'd8,  4'b0, 4'b0);
    beat(1'b1, 1'b0, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'd12, 4'b0, 4'b0);
    beat(1'b1, 1'b0, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'd15, 4'b0, 4'b0);
    beat(1'b1, 1'b0, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'd15, 4'b0, 4'b0);
    // Clear wins over an accepted beat.
    beat(1'b1, 1'b1, 4'b1100, 4'b1010, 4'b0110, 4'b0010, 4'd0, 4'b0, 4'b0);
    beat(1'b1, 1'b0, 4'b1100, 4'b1010, 4'b0110, 4'b0010, 4'd1, 4'b0, 4'b0);
    beat(1'b1, 1'b0, 4'b1110, 4'b0111, 4'b1001, 4'b0001, 4'd2, 4'b0, 4'b0);

    // Reset between edges while a registered result is pending.
    check("pre_rst_out_valid", 32'(out_valid),  32'd1);
    check("pre_rst_cnt",       32'(borrow_cnt), 32'd2);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid),  32'd0);
    check("mid_rst_diff_q",    32'(diff_q),     32'd0);
    check("mid_rst_borrow_q",  32'(borrow_q),   32'd0);
    check("mid_rst_cnt",       32'(borrow_cnt), 32'd0);
    check("mid_rst_diff",      32'(diff),       32'(4'b1001));
    check("mid_rst_borrow",    32'(borrow_out), 32'(4'b0001));
    sb.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after reset behaves normally.
    beat(1'b1, 1'b0, 4'b0000, 4'b0101, 4'b0101, 4'b0101, 4'd2, 4'b0, 4'b0);
    beat(1'b0, 1'b0, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 4'd2, 4'b0101, 4'b0101);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
